// File: rtl/uart_lite_slave.sv
// AXI4-Lite UART-Lite responder: RX/TX byte FIFOs, 8N1 transmitter and receiver,
// STAT/CTRL registers and a one-cycle interrupt pulse.

module uart_lite_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_r == (AW+1)'(0));
   assign full    = (count_r == (AW+1)'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr_r];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= (AW+1)'(0);
      end else if (flush) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= (AW+1)'(0);
      end else begin
         if (do_push) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (do_pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage carries no reset; reads of an empty FIFO are masked by the user.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr_r] <= din;
   end
endmodule

module uart_lite_slave #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  ARADDR,
   input  logic        ARVALID,
   output logic        ARREADY,
   output logic [31:0] RDATA,
   output logic [1:0]  RRESP,
   output logic        RVALID,
   input  logic        RREADY,
   input  logic [3:0]  AWADDR,
   input  logic        AWVALID,
   output logic        AWREADY,
   input  logic [31:0] WDATA,
   input  logic [3:0]  WSTRB,
   input  logic        WVALID,
   output logic        WREADY,
   output logic [1:0]  BRESP,
   output logic        BVALID,
   input  logic        BREADY,
   output logic        TXD,
   input  logic        RXD,
   output logic        INTERRUPT
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   logic        rvalid_r, bvalid_r, aw_held_r, w_held_r, wstrb0_r;
   logic [31:0] rdata_r, rd_mux, stat;
   logic [1:0]  awaddr_r;
   logic [7:0]  wdata_r;
   logic        intr_en_r, ovr_r, ferr_r, intr_r, rx_empty_d_r, tx_empty_d_r;
   logic        ar_hs, stat_rd, wr_exec, ctrl_wr;
   logic        tx_push, tx_pop, tx_flush, tx_empty, tx_full;
   logic        rx_push, rx_pop, rx_flush, rx_empty, rx_full;
   logic [7:0]  tx_dout, rx_dout;
   logic        unused_bits;

   tx_state_t   tx_state_r, tx_state_n;
   logic [CW-1:0] tx_cnt_r, tx_cnt_n;
   logic [2:0]  tx_bit_r, tx_bit_n;
   logic [7:0]  tx_sh_r, tx_sh_n;
   logic        txd_r, txd_n;

   rx_state_t   rx_state_r, rx_state_n;
   logic [CW-1:0] rx_cnt_r, rx_cnt_n;
   logic [2:0]  rx_bit_r, rx_bit_n;
   logic [7:0]  rx_sh_r, rx_sh_n;
   logic [1:0]  rx_sync_r;
   logic        rx_prev_r, rx_in, set_ovr, set_ferr;

   assign unused_bits = ^{ARADDR[1:0], AWADDR[1:0], WDATA[31:8], WSTRB[3:1]};

   assign ARREADY   = ~rvalid_r;
   assign RVALID    = rvalid_r;
   assign RDATA     = rdata_r;
   assign RRESP     = 2'b00;
   assign AWREADY   = ~aw_held_r & ~bvalid_r;
   assign WREADY    = ~w_held_r & ~bvalid_r;
   assign BVALID    = bvalid_r;
   assign BRESP     = 2'b00;
   assign TXD       = txd_r;
   assign INTERRUPT = intr_r;

   assign ar_hs    = ARVALID & ~rvalid_r;
   assign stat_rd  = ar_hs & (ARADDR[3:2] == 2'b10);
   assign rx_pop   = ar_hs & (ARADDR[3:2] == 2'b00);
   assign wr_exec  = aw_held_r & w_held_r;
   assign tx_push  = wr_exec & wstrb0_r & (awaddr_r == 2'b01);
   assign ctrl_wr  = wr_exec & wstrb0_r & (awaddr_r == 2'b11);
   assign tx_flush = ctrl_wr & wdata_r[0];
   assign rx_flush = ctrl_wr & wdata_r[1];
   assign rx_in    = rx_sync_r[1];
   assign stat     = {25'd0, ferr_r, ovr_r, intr_en_r, tx_full, tx_empty, rx_full, ~rx_empty};

   uart_lite_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
      .clk(CLK), .rst(RST), .flush(tx_flush), .push(tx_push), .pop(tx_pop),
      .din(wdata_r), .dout(tx_dout), .empty(tx_empty), .full(tx_full)
   );

   uart_lite_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
      .clk(CLK), .rst(RST), .flush(rx_flush), .push(rx_push), .pop(rx_pop),
      .din(rx_sh_r), .dout(rx_dout), .empty(rx_empty), .full(rx_full)
   );

   always_comb begin
      rd_mux = 32'd0;
      case (ARADDR[3:2])
         2'b00:   rd_mux = {24'd0, rx_empty ? 8'd0 : rx_dout};
         2'b10:   rd_mux = stat;
         default: rd_mux = 32'd0;
      endcase
   end

   // AXI read/write channels, control register and sticky error flags.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rvalid_r  <= 1'b0;
         rdata_r   <= 32'd0;
         aw_held_r <= 1'b0;
         w_held_r  <= 1'b0;
         awaddr_r  <= 2'b00;
         wdata_r   <= 8'd0;
         wstrb0_r  <= 1'b0;
         bvalid_r  <= 1'b0;
         intr_en_r <= 1'b0;
         ovr_r     <= 1'b0;
         ferr_r    <= 1'b0;
      end else begin
         if (ar_hs) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_mux;
         end else if (rvalid_r && RREADY) begin
            rvalid_r <= 1'b0;
         end
         if (wr_exec) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            bvalid_r  <= 1'b1;
         end else begin
            if (AWVALID && AWREADY) begin
               aw_held_r <= 1'b1;
               awaddr_r  <= AWADDR[3:2];
            end
            if (WVALID && WREADY) begin
               w_held_r <= 1'b1;
               wdata_r  <= WDATA[7:0];
               wstrb0_r <= WSTRB[0];
            end
            if (bvalid_r && BREADY) bvalid_r <= 1'b0;
         end
         if (ctrl_wr) intr_en_r <= wdata_r[4];
         // A new error in the same cycle as a STAT read must survive the clear.
         ovr_r  <= set_ovr | (ovr_r & ~stat_rd);
         ferr_r <= set_ferr | (ferr_r & ~stat_rd);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rx_empty_d_r <= 1'b1;
         tx_empty_d_r <= 1'b1;
         intr_r       <= 1'b0;
      end else begin
         rx_empty_d_r <= rx_empty;
         tx_empty_d_r <= tx_empty;
         intr_r       <= intr_en_r & ((rx_empty_d_r & ~rx_empty) | (~tx_empty_d_r & tx_empty));
      end
   end

   always_comb begin
      tx_state_n = tx_state_r;
      tx_cnt_n   = tx_cnt_r + CW'(1);
      tx_bit_n   = tx_bit_r;
      tx_sh_n    = tx_sh_r;
      txd_n      = txd_r;
      tx_pop     = 1'b0;
      case (tx_state_r)
         TX_IDLE: begin
            tx_cnt_n = CW'(0);
            txd_n    = 1'b1;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_sh_n    = tx_dout;
               txd_n      = 1'b0;
               tx_state_n = TX_START;
            end else begin
               tx_state_n = TX_IDLE;
            end
         end
         TX_START: begin
            if (tx_cnt_r == BIT_LAST) begin
               tx_cnt_n   = CW'(0);
               tx_bit_n   = 3'd0;
               txd_n      = tx_sh_r[0];
               tx_state_n = TX_DATA;
            end else begin
               tx_state_n = TX_START;
            end
         end
         TX_DATA: begin
            if (tx_cnt_r == BIT_LAST) begin
               tx_cnt_n = CW'(0);
               if (tx_bit_r == 3'd7) begin
                  txd_n      = 1'b1;
                  tx_state_n = TX_STOP;
               end else begin
                  tx_bit_n = tx_bit_r + 3'd1;
                  tx_sh_n  = {1'b0, tx_sh_r[7:1]};
                  txd_n    = tx_sh_r[1];
               end
            end else begin
               tx_state_n = TX_DATA;
            end
         end
         TX_STOP: begin
            if (tx_cnt_r == BIT_LAST) begin
               tx_cnt_n = CW'(0);
               // Chain straight into the next start bit when more data waits.
               if (!tx_empty) begin
                  tx_pop     = 1'b1;
                  tx_sh_n    = tx_dout;
                  txd_n      = 1'b0;
                  tx_state_n = TX_START;
               end else begin
                  tx_state_n = TX_IDLE;
               end
            end else begin
               tx_state_n = TX_STOP;
            end
         end
         default: begin
            tx_state_n = TX_IDLE;
            txd_n      = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tx_state_r <= TX_IDLE;
         tx_cnt_r   <= CW'(0);
         tx_bit_r   <= 3'd0;
         tx_sh_r    <= 8'd0;
         txd_r      <= 1'b1;
      end else begin
         tx_state_r <= tx_state_n;
         tx_cnt_r   <= tx_cnt_n;
         tx_bit_r   <= tx_bit_n;
         tx_sh_r    <= tx_sh_n;
         txd_r      <= txd_n;
      end
   end

   always_comb begin
      rx_state_n = rx_state_r;
      rx_cnt_n   = rx_cnt_r + CW'(1);
      rx_bit_n   = rx_bit_r;
      rx_sh_n    = rx_sh_r;
      rx_push    = 1'b0;
      set_ovr    = 1'b0;
      set_ferr   = 1'b0;
      case (rx_state_r)
         RX_IDLE: begin
            rx_cnt_n = CW'(0);
            if (rx_prev_r && !rx_in) rx_state_n = RX_START;
            else                     rx_state_n = RX_IDLE;
         end
         RX_START: begin
            if (rx_cnt_r == HALF_LAST) begin
               rx_cnt_n   = CW'(0);
               rx_bit_n   = 3'd0;
               rx_state_n = rx_in ? RX_IDLE : RX_DATA;
            end else begin
               rx_state_n = RX_START;
            end
         end
         RX_DATA: begin
            if (rx_cnt_r == BIT_LAST) begin
               rx_cnt_n = CW'(0);
               rx_sh_n  = {rx_in, rx_sh_r[7:1]};
               if (rx_bit_r == 3'd7) rx_state_n = RX_STOP;
               else                  rx_bit_n   = rx_bit_r + 3'd1;
            end else begin
               rx_state_n = RX_DATA;
            end
         end
         RX_STOP: begin
            if (rx_cnt_r == BIT_LAST) begin
               rx_state_n = RX_IDLE;
               if (!rx_in)       set_ferr = 1'b1;
               else if (rx_full) set_ovr  = 1'b1;
               else              rx_push  = 1'b1;
            end else begin
               rx_state_n = RX_STOP;
            end
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rx_sync_r  <= 2'b11;
         rx_prev_r  <= 1'b1;
         rx_state_r <= RX_IDLE;
         rx_cnt_r   <= CW'(0);
         rx_bit_r   <= 3'd0;
         rx_sh_r    <= 8'd0;
      end else begin
         rx_sync_r  <= {rx_sync_r[0], RXD};
         rx_prev_r  <= rx_in;
         rx_state_r <= rx_state_n;
         rx_cnt_r   <= rx_cnt_n;
         rx_bit_r   <= rx_bit_n;
         rx_sh_r    <= rx_sh_n;
      end
   end
endmodule

// File: tb/tb_uart_lite_slave.sv
// Directed bench for uart_lite_slave: expected read data and serial bits are queued
// when stimulus is issued and popped when the DUT produces them.

module tb_uart_lite_slave;
   localparam int CPB   = 8;
   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [3:0]  ARADDR = 4'h0;
   logic        ARVALID = 1'b0;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY = 1'b0;
   logic [3:0]  AWADDR = 4'h0;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [31:0] WDATA = 32'd0;
   logic [3:0]  WSTRB = 4'h0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY = 1'b0;
   logic        TXD;
   logic        RXD = 1'b1;
   logic        INTERRUPT;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          intr_cnt = 0;
   logic [31:0] exp_q[$];

   uart_lite_slave #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .TXD(TXD), .RXD(RXD), .INTERRUPT(INTERRUPT)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (INTERRUPT === 1'b1) intr_cnt <= intr_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sb_check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      n_assert++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s: observed %h with empty scoreboard", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
      int k;
      @(negedge CLK);
      ARADDR  = a;
      ARVALID = 1'b1;
      k = 0;
      while (ARREADY !== 1'b1 && k < 50) begin
         @(negedge CLK);
         k++;
      end
      check_eq("arready", {31'd0, ARREADY}, 32'd1);
      @(posedge CLK);
      #1;
      ARVALID = 1'b0;
      check_eq("rvalid_set", {31'd0, RVALID}, 32'd1);
      check_eq("rresp", {30'd0, RRESP}, 32'd0);
      d = RDATA;
      @(negedge CLK);
      RREADY = 1'b1;
      @(posedge CLK);
      #1;
      RREADY = 1'b0;
      check_eq("rvalid_clr", {31'd0, RVALID}, 32'd0);
   endtask

   task automatic rd_expect(input string tag, input logic [3:0] a, input logic [31:0] e);
      logic [31:0] d;
      exp_q.push_back(e);
      axi_read(a, d);
      sb_check(tag, d);
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int wdel, input int bdel);
      @(negedge CLK);
      AWADDR  = a;
      AWVALID = 1'b1;
      if (wdel == 0) begin
         WDATA  = d;
         WSTRB  = s;
         WVALID = 1'b1;
      end
      check_eq("awready", {31'd0, AWREADY}, 32'd1);
      @(posedge CLK);
      #1;
      AWVALID = 1'b0;
      if (wdel == 0) begin
         WVALID = 1'b0;
      end else begin
         repeat (wdel) @(negedge CLK);
         check_eq("awready_held", {31'd0, AWREADY}, 32'd0);
         check_eq("wready", {31'd0, WREADY}, 32'd1);
         WDATA  = d;
         WSTRB  = s;
         WVALID = 1'b1;
         @(posedge CLK);
         #1;
         WVALID = 1'b0;
      end
      @(posedge CLK);
      #1;
      check_eq("bvalid_set", {31'd0, BVALID}, 32'd1);
      check_eq("bresp", {30'd0, BRESP}, 32'd0);
      for (int i = 0; i < bdel; i++) begin
         @(posedge CLK);
         #1;
         check_eq("bvalid_hold", {31'd0, BVALID}, 32'd1);
      end
      @(negedge CLK);
      BREADY = 1'b1;
      @(posedge CLK);
      #1;
      BREADY = 1'b0;
      check_eq("bvalid_clr", {31'd0, BVALID}, 32'd0);
   endtask

   task automatic push_frame(input logic [7:0] b);
      exp_q.push_back(32'd0);
      for (int i = 0; i < 8; i++) exp_q.push_back({31'd0, b[i]});
      exp_q.push_back(32'd1);
   endtask

   task automatic tx_capture(input string tag);
      int k;
      k = 0;
      while (TXD !== 1'b0 && k < 400) begin
         @(posedge CLK);
         #1;
         k++;
      end
      repeat (CPB / 2) @(posedge CLK);
      #1;
      sb_check(tag, {31'd0, TXD});
      for (int i = 1; i < 10; i++) begin
         repeat (CPB) @(posedge CLK);
         #1;
         sb_check(tag, {31'd0, TXD});
      end
   endtask

   task automatic check_idle(input string tag, input int cycles);
      logic low;
      low = 1'b0;
      repeat (cycles) begin
         @(posedge CLK);
         #1;
         if (TXD !== 1'b1) low = 1'b1;
      end
      check_eq(tag, {31'd0, low}, 32'd0);
   endtask

   task automatic rx_send(input logic [7:0] b, input logic stop);
      @(negedge CLK);
      RXD = 1'b0;
      repeat (CPB) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         RXD = b[i];
         repeat (CPB) @(negedge CLK);
      end
      RXD = stop;
      repeat (CPB) @(negedge CLK);
      RXD = 1'b1;
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      // Reset values while RST is held
      repeat (3) @(posedge CLK);
      #1;
      check_eq("rst_txd", {31'd0, TXD}, 32'd1);
      check_eq("rst_rvalid", {31'd0, RVALID}, 32'd0);
      check_eq("rst_bvalid", {31'd0, BVALID}, 32'd0);
      check_eq("rst_intr", {31'd0, INTERRUPT}, 32'd0);
      check_eq("rst_rdata", RDATA, 32'd0);
      @(negedge CLK);
      RST = 1'b0;

      // STAT after reset and reads of empty / write-only locations
      rd_expect("stat_reset", 4'h8, 32'h0000_0004);
      rd_expect("rx_empty_read", 4'h0, 32'd0);
      rd_expect("tx_addr_read", 4'h4, 32'd0);
      rd_expect("ctrl_read", 4'hC, 32'd0);

      // Transmit 0x55
      push_frame(8'h55);
      fork
         axi_write(4'h4, 32'h0000_0055, 4'hF, 0, 0);
         tx_capture("tx_0x55");
      join
      rd_expect("stat_tx_done", 4'h8, 32'h0000_0004);
      check_eq("intr_disabled", intr_cnt, 32'd0);

      // Receive 0xA3 with interrupts enabled
      axi_write(4'hC, 32'h0000_0010, 4'h1, 0, 0);
      rd_expect("stat_intr_en", 4'h8, 32'h0000_0014);
      rx_send(8'hA3, 1'b1);
      rd_expect("stat_rx_avail", 4'h8, 32'h0000_0015);
      rd_expect("rx_data_a3", 4'h0, 32'h0000_00A3);
      rd_expect("stat_rx_drained", 4'h8, 32'h0000_0014);
      check_eq("intr_rx_pulse", intr_cnt, 32'd1);
      axi_write(4'hC, 32'h0000_0000, 4'h1, 0, 0);

      // Overrun: DEPTH+1 frames with no reads
      for (int i = 0; i <= DEPTH; i++) rx_send(8'h10 + 8'(i), 1'b1);
      rd_expect("stat_overrun", 4'h8, 32'h0000_0027);
      rd_expect("stat_ovr_cleared", 4'h8, 32'h0000_0007);
      rd_expect("rx_first", 4'h0, 32'h0000_0010);
      rd_expect("rx_second", 4'h0, 32'h0000_0011);
      rd_expect("stat_partial", 4'h8, 32'h0000_0005);
      axi_write(4'hC, 32'h0000_0002, 4'h1, 0, 0);
      rd_expect("stat_rx_flushed", 4'h8, 32'h0000_0004);
      rd_expect("rx_after_flush", 4'h0, 32'd0);

      // TX push without WSTRB[0] is dropped
      axi_write(4'h4, 32'h0000_003C, 4'h0, 0, 0);
      check_idle("strb0_no_frame", 3 * CPB);

      // AW ahead of W, BREADY late: exactly one frame
      push_frame(8'h3C);
      fork
         axi_write(4'h4, 32'h0000_003C, 4'h1, 2, 3);
         tx_capture("tx_0x3c");
      join
      check_idle("single_write", 12 * CPB);
      rd_expect("stat_after_single", 4'h8, 32'h0000_0004);

      // Frame error: stop bit sampled low
      rx_send(8'h5A, 1'b0);
      rd_expect("stat_frame_err", 4'h8, 32'h0000_0044);
      rd_expect("stat_ferr_cleared", 4'h8, 32'h0000_0004);
      rd_expect("rx_no_push", 4'h0, 32'd0);

      // Asynchronous reset in the middle of a TX frame
      axi_write(4'h4, 32'h0000_0000, 4'h1, 0, 0);
      repeat (20) @(posedge CLK);
      #2;
      check_eq("txd_mid_frame", {31'd0, TXD}, 32'd0);
      RST = 1'b1;
      #1;
      check_eq("txd_async_reset", {31'd0, TXD}, 32'd1);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      check_idle("txd_after_reset", 12 * CPB);
      rd_expect("stat_after_reset", 4'h8, 32'h0000_0004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
